half_adder: RTL and testbench
=============================

// Module: half_adder
// PURPOSE
// - Vector of WIDTH independent 1-bit half adders: sum = a ^ b, carry = a & b, per lane.
// - Combinational results serve datapath glue logic.
// - A registered, valid-qualified copy serves timing-critical consumers in the clk domain.
// PARAMETERS
// - WIDTH    default 1   number of independent half-adder lanes (>=1)
// - CNT_W    default 16  width of carry-event counter (used only with HALF_ADDER_CNT_EN)
// PORTS
// - clk        in   1        single clock; all registers rising-edge
// - rst        in   1        synchronous, active-high reset
// - a          in   WIDTH    operand A, lane i = a[i]
// - b          in   WIDTH    operand B, lane i = b[i]
// - in_valid   in   1        qualifies a/b for the registered path
// - sum        out  WIDTH    combinational a ^ b
// - carry      out  WIDTH    combinational a & b
// - sum_q      out  WIDTH    registered sum
// - carry_q    out  WIDTH    registered carry
// - out_valid  out  1        sum_q/carry_q hold a captured result
// - carry_cnt  out  CNT_W    count of cycles with in_valid & |carry (see CONFIGURATION)
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Combinational path: sum/carry follow a/b with zero latency, no clock dependency.
//   - Truth table per lane: 00->s0 c0, 01->s1 c0, 10->s1 c0, 11->s0 c1.
//   - X on an input lane propagates only to that lane.
// - Registered path, 1-cycle latency:
//   - in_valid=1 at edge N: sum_q/carry_q load sum/carry; out_valid=1 after edge N.
//   - in_valid=0: sum_q/carry_q hold their value; out_valid=0 after the edge.
//   - No backpressure; each valid input produces exactly one out_valid pulse per cycle.
// - Reset: at an edge with rst=1, sum_q=0, carry_q=0, out_valid=0, carry_cnt=0.
//   - rst dominates in_valid in the same cycle.
//   - Combinational sum/carry are unaffected by rst.
// - Lanes never interact; there is no carry chaining between lanes.
// CONFIGURATION
// - Macro HALF_ADDER_CNT_EN defined:
//   - carry_cnt increments by 1 on each edge where in_valid & (|carry) and rst=0.
//   - Saturates at 2^CNT_W-1, never wraps; cleared only by rst.
// - Macro undefined: counter logic is absent and carry_cnt is tied to 0.
// - The port list is identical in both builds.
// STRUCTURE
// - Package half_adder_pkg: DEF_WIDTH=1, DEF_CNT_W=16; typedef for the lane result struct {sum, carry}.
// - Sub-module half_adder_cell: 1-bit combinational (a, b -> sum, carry).
//   - Generate one cell per lane.
// - Top holds the output register, valid flop and optional counter.
// TESTING
// - Exhaustive, WIDTH=1, 10 ns per step:
//   - a,b = 00/01/10/11 -> sum,carry = 0,0 / 1,0 / 1,0 / 0,1.
//   - Combinational outputs settle the same step.
// - Registered path: in_valid=1 with a=1,b=1 -> next edge carry_q=1, sum_q=0, out_valid=1.
//   - Drop in_valid -> out_valid=0; sum_q/carry_q hold.
// - Reset priority: rst=1 and in_valid=1 with a=b=1 -> after edge sum_q=0, carry_q=0, out_valid=0, carry_cnt=0.
// - Lane isolation, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000.
// - HALF_ADDER_CNT_EN, CNT_W=2:
//   - Five valid cycles with a=b=1 -> carry_cnt 1,2,3,3,3 (saturation).
//   - Undefined build -> carry_cnt stays 0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared definitions for the half_adder lane vector.
// Default parameter values and the per-lane result record.
package half_adder_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 16;

    // Result of one half-adder lane.
    typedef struct packed {
        logic sum;
        logic carry;
    } lane_res_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder: sum = a ^ b, carry = a & b.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    output lane_res_t res_o
);

    // Pure lane function; an X on either input stays confined to this lane.
    always_comb begin
        res_o.sum   = a_i ^ b_i;
        res_o.carry = a_i & b_i;
    end

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a combinational result, a
// valid-qualified registered copy and an optional saturating carry-event
// counter. Define HALF_ADDER_CNT_EN to build the counter; otherwise
// carry_cnt is tied to zero. The port list is the same in both builds.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    lane_res_t lane_res [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a_i   (a[i]),
            .b_i   (b[i]),
            .res_o (lane_res[i])
        );
        assign sum[i]   = lane_res[i].sum;
        assign carry[i] = lane_res[i].carry;
    end

    logic [WIDTH-1:0] sum_r_q, sum_r_d;
    logic [WIDTH-1:0] carry_r_q, carry_r_d;
    logic             valid_q, valid_d;

    // Capture the lane results on valid input, otherwise hold; valid is a one-cycle pulse.
    always_comb begin
        sum_r_d   = sum_r_q;
        carry_r_d = carry_r_q;
        valid_d   = 1'b0;
        if (in_valid) begin
            sum_r_d   = sum;
            carry_r_d = carry;
            valid_d   = 1'b1;
        end
    end

    // Output register and valid flop; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r_q   <= '0;
            carry_r_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            sum_r_q   <= sum_r_d;
            carry_r_q <= carry_r_d;
            valid_q   <= valid_d;
        end
    end

    assign sum_q     = sum_r_q;
    assign carry_q   = carry_r_q;
    assign out_valid = valid_q;

`ifdef HALF_ADDER_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count valid cycles in which any lane carries; stop at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && (|carry) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`else
    assign carry_cnt = '0;
`endif

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder: a WIDTH=1/CNT_W=2 instance
// for truth table, registered path, reset priority and counter saturation,
// plus a WIDTH=4 instance for lane isolation.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic [0:0] sum1, carry1, sum_q1, carry_q1;
    logic       out_valid1;
    logic [1:0] cnt1;

    logic [3:0]  sum4, carry4, sum_q4, carry_q4;
    logic        out_valid4;
    logic [15:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .in_valid  (in_valid),
        .sum       (sum1),
        .carry     (carry1),
        .sum_q     (sum_q1),
        .carry_q   (carry_q1),
        .out_valid (out_valid1),
        .carry_cnt (cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .a         (a4),
        .b         (b4),
        .in_valid  (in_valid),
        .sum       (sum4),
        .carry     (carry4),
        .sum_q     (sum_q4),
        .carry_q   (carry_q4),
        .out_valid (out_valid4),
        .carry_cnt (cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected counter value: the hand-computed count with the counter built, else zero.
    function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef HALF_ADDER_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ab_vec   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] exp_sc   [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    int unsigned sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        tick(); tick();
        check("rst_sum_q",     sum_q1,     0);
        check("rst_carry_q",   carry_q1,   0);
        check("rst_out_valid", out_valid1, 0);
        check("rst_cnt",       cnt1,       0);

        // Exhaustive combinational truth table, in_valid low.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v, e;
            v = ab_vec[i];
            e = exp_sc[i];
            a1 = v[1]; b1 = v[0];
            #10;
            check($sformatf("tt_sum_%0d", i),   sum1,   e[1]);
            check($sformatf("tt_carry_%0d", i), carry1, e[0]);
        end

        // Registered path: capture a=b=1.
        a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
        tick();
        check("reg_sum_q",     sum_q1,     0);
        check("reg_carry_q",   carry_q1,   1);
        check("reg_out_valid", out_valid1, 1);
        check("reg_cnt",       cnt1,       exp_cnt(1));

        // Drop valid with different inputs: outputs hold, valid drops.
        in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("hold_sum_q",     sum_q1,     0);
        check("hold_carry_q",   carry_q1,   1);
        check("hold_out_valid", out_valid1, 0);
        check("hold_cnt",       cnt1,       exp_cnt(1));
        check("hold_comb_sum",  sum1,       1);

        // Reset dominates a valid carry-producing input.
        rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1;
        #1;
        check("rst_comb_sum",   sum1,   0);
        check("rst_comb_carry", carry1, 1);
        tick();
        check("rstp_sum_q",     sum_q1,     0);
        check("rstp_carry_q",   carry_q1,   0);
        check("rstp_out_valid", out_valid1, 0);
        check("rstp_cnt",       cnt1,       0);

        // Valid cycle without carry: captured, but not counted.
        rst = 1'b0; a1 = 1'b1; b1 = 1'b0;
        tick();
        check("nc_sum_q",     sum_q1,     1);
        check("nc_carry_q",   carry_q1,   0);
        check("nc_out_valid", out_valid1, 1);
        check("nc_cnt",       cnt1,       0);

        // Five carry cycles: counter saturates at 3 with CNT_W=2.
        a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_cnt_%0d", i), cnt1, exp_cnt(sat_exp[i]));
        end
        check("sat_out_valid", out_valid1, 1);

        // Lane isolation on the 4-lane instance.
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("lane_sum",   sum4,   4'b0110);
        check("lane_carry", carry4, 4'b1000);
        tick();
        check("lane_sum_q",   sum_q4,   4'b0110);
        check("lane_carry_q", carry_q4, 4'b1000);
        check("lane_valid",   out_valid4, 1);
        in_valid = 1'b0;
        a4 = 4'b1111; b4 = 4'b0101;
        #1;
        check("lane2_sum",   sum4,   4'b1010);
        check("lane2_carry", carry4, 4'b0101);
        tick();
        check("lane2_hold_sum_q",   sum_q4,     4'b0110);
        check("lane2_hold_carry_q", carry_q4,   4'b1000);
        check("lane2_valid",        out_valid4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_half_adder
